mu0_sequencer: RTL

//  Fetch/execute control FSM for the MU0 12-bit datapath. Drives address-mux select (PC vs IR[11:0]),
//  ALU operand selects and function, register clock-enables and the memory request/handshake.

---
 rtl/mu0_pkg.sv | 24 ++
 rtl/mu0_wait_timer.sv | 37 +++
 rtl/mu0_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// Shared encodings for the MU0 control path: FSM states, opcodes, ALU function codes.
package mu0_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_HALT    = 2'd2
  } state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] FS_PASSY = 2'b00;
  localparam logic [1:0] FS_ADD   = 2'b01;
  localparam logic [1:0] FS_INC   = 2'b10;
  localparam logic [1:0] FS_SUB   = 2'b11;

endpackage

// File: rtl/mu0_wait_timer.sv
// Memory-acknowledge wait counter: counts unacknowledged request cycles and
// flags when the next unacknowledged cycle would be the TIMEOUT-th one.
module mu0_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: a state change restarts the wait, otherwise count stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 fetch/execute sequencer. Outputs are combinational from state, opcode,
// flags and mem_ack; state, wait count and sticky error bits are registered.
// Handshake: a memory access is offered while mem_rq=1 and completes in the
// cycle mem_ack=1; mem_ack with mem_rq=0 is ignored.
module mu0_sequencer
  import mu0_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       flag_n,
  input  logic       flag_z,
  input  logic       mem_ack,
  output logic       addr_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic [1:0] alu_fs,
  output logic       acc_ce,
  output logic       pc_ce,
  output logic       ir_ce,
  output logic       acc_oe,
  output logic       mem_rq,
  output logic       mem_rnw,
  output logic       halted,
  output logic       err_ill,
  output logic       err_tmo
);

  state_e state_q, state_d;
  logic   err_ill_q, err_ill_d;
  logic   err_tmo_q, err_tmo_d;
  logic   expire;
  logic   rq_int;

  mu0_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_d != state_q),
    .inc    (rq_int & ~mem_ack),
    .expire (expire)
  );

  // Next-state and control outputs; everything forced low while reset is high.
  always_comb begin
    state_d   = state_q;
    err_ill_d = err_ill_q;
    err_tmo_d = err_tmo_q;
    addr_sel  = 1'b0;
    x_sel     = 1'b0;
    y_sel     = 1'b0;
    alu_fs    = FS_PASSY;
    acc_ce    = 1'b0;
    pc_ce     = 1'b0;
    ir_ce     = 1'b0;
    acc_oe    = 1'b0;
    rq_int    = 1'b0;
    mem_rnw   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        rq_int  = 1'b1;
        mem_rnw = 1'b1;
        x_sel   = 1'b1;
        alu_fs  = FS_INC;
        if (mem_ack) begin
          ir_ce   = 1'b1;
          pc_ce   = 1'b1;
          state_d = S_EXECUTE;
        end else if (expire) begin
          state_d   = S_HALT;
          err_tmo_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            addr_sel = 1'b1;
            rq_int   = 1'b1;
            mem_rnw  = (opcode != OP_STA);
            acc_oe   = (opcode == OP_STA);
            alu_fs   = (opcode == OP_ADD) ? FS_ADD :
                       (opcode == OP_SUB) ? FS_SUB : FS_PASSY;
            if (mem_ack) begin
              acc_ce  = (opcode != OP_STA);
              state_d = S_FETCH;
            end else if (expire) begin
              state_d   = S_HALT;
              err_tmo_d = 1'b1;
            end
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            y_sel   = 1'b1;
            alu_fs  = FS_PASSY;
            pc_ce   = (opcode == OP_JMP) ? 1'b1 :
                      (opcode == OP_JGE) ? ~flag_n : ~flag_z;
            state_d = S_FETCH;
          end
          OP_STP: begin
            state_d = S_HALT;
          end
          default: begin
            state_d   = S_HALT;
            err_ill_d = 1'b1;
          end
        endcase
      end
      default: begin
        halted = 1'b1;
      end
    endcase
    if (reset) begin
      addr_sel = 1'b0;
      x_sel    = 1'b0;
      y_sel    = 1'b0;
      alu_fs   = 2'b00;
      acc_ce   = 1'b0;
      pc_ce    = 1'b0;
      ir_ce    = 1'b0;
      acc_oe   = 1'b0;
      mem_rnw  = 1'b0;
      halted   = 1'b0;
    end
  end

  assign mem_rq  = rq_int & ~reset;
  assign err_ill = err_ill_q & ~reset;
  assign err_tmo = err_tmo_q & ~reset;

  // State and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      err_ill_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_ill_q <= err_ill_d;
      err_tmo_q <= err_tmo_d;
    end
  end

endmodule
